// File: rtl/bus_mem_responder.sv
// Byte RAM responder on an 8-bit data / 16-bit address bus: strobe-edge
// triggered reads with configurable latency, single-commit writes, sticky r+w error.
module bus_mem_responder #(
  parameter logic [15:0] BASE     = 16'h2000,
  parameter int          ADDR_W   = 12,
  parameter int          READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] adress_bus,
  input  logic [7:0]  date_in,
  output logic [7:0]  date_out,
  output logic        date_oe,
  input  logic        r,
  input  logic        w,
  output logic        ack,
  output logic        access_err,
  output logic [2:0]  dbg_state_o
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RD_WAIT   = 3'd1;
  localparam logic [2:0] RD_DRIVE  = 3'd2;
  localparam logic [2:0] WR_COMMIT = 3'd3;
  localparam logic [2:0] WR_HOLD   = 3'd4;

  logic [7:0]        mem [0:DEPTH-1];

  logic [2:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        dout_q, dout_d;
  logic              oe_q, oe_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              r_prev_q, w_prev_q;

  logic hit, r_rise, w_rise, mem_we;

  assign hit    = (adress_bus[15:ADDR_W] == BASE[15:ADDR_W]);
  assign r_rise = r && !r_prev_q;
  assign w_rise = w && !w_prev_q;
  assign mem_we = (state_q == WR_COMMIT);

  // Handshake: a request is recognised only on a strobe rise seen in IDLE;
  // read data is valid (ack=1, date_oe=1) until r drops; a write is
  // acknowledged by a single-cycle ack after the array commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    ack_d   = ack_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (hit && r && w) begin
          err_d = 1'b1;
        end else if (hit && r_rise) begin
          idx_d   = adress_bus[ADDR_W-1:0];
          cnt_d   = READ_LAT[1:0];
          state_d = RD_WAIT;
        end else if (hit && w_rise) begin
          idx_d   = adress_bus[ADDR_W-1:0];
          wdata_d = date_in;
          state_d = WR_COMMIT;
        end
      end
      RD_WAIT: begin
        if (!r) begin
          state_d = IDLE;
        end else if (cnt_q == 2'd0) begin
          dout_d  = mem[idx_q];
          oe_d    = 1'b1;
          ack_d   = 1'b1;
          state_d = RD_DRIVE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RD_DRIVE: begin
        if (!r || w) begin
          oe_d    = 1'b0;
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      WR_COMMIT: begin
        ack_d   = 1'b1;
        state_d = WR_HOLD;
      end
      WR_HOLD: begin
        ack_d = 1'b0;
        if (!w) state_d = IDLE;
      end
      default: begin
        oe_d    = 1'b0;
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      idx_q    <= '0;
      wdata_q  <= 8'h00;
      dout_q   <= 8'h00;
      oe_q     <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      r_prev_q <= 1'b0;
      w_prev_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      dout_q   <= dout_d;
      oe_q     <= oe_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      r_prev_q <= r;
      w_prev_q <= w;
    end
  end

  // Array contents survive reset, so the storage has no reset branch.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end

  // Gating with w keeps the bus free of contention even mid-cycle.
  assign date_oe     = oe_q && !w;
  assign date_out    = dout_q;
  assign ack         = ack_q;
  assign access_err  = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: inputs driven on negedge, outputs
// sampled 1ns after posedge.
module tb_bus_mem_responder;

  localparam int RL = 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_WAIT = 3'd1;
  localparam logic [2:0] S_WR_COMM = 3'd3;

  logic        clk;
  logic        reset;
  logic [15:0] adress_bus;
  logic [7:0]  date_in;
  logic [7:0]  date_out;
  logic        date_oe;
  logic        r;
  logic        w;
  logic        ack;
  logic        access_err;
  logic [2:0]  dbg_state;

  int errors;
  int checks;

  bus_mem_responder #(
    .BASE(16'h2000),
    .ADDR_W(12),
    .READ_LAT(RL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .adress_bus(adress_bus),
    .date_in(date_in),
    .date_out(date_out),
    .date_oe(date_oe),
    .r(r),
    .w(w),
    .ack(ack),
    .access_err(access_err),
    .dbg_state_o(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [15:0] a, input logic [7:0] d,
                          input int hold, input bit vary, input string name);
    int ack_cnt;
    ack_cnt = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      adress_bus = a;
      w = 1'b1;
      date_in = (vary && i > 0) ? (d ^ 8'(i * 8'h13)) : d;
      @(posedge clk); #1;
      if (ack) ack_cnt++;
      checks++;
      if (date_oe !== 1'b0) begin
        errors++;
        $display("FAIL %s oe_during_w cyc=%0d: got %b want 0", name, i, date_oe);
      end
      if (i == 0) begin
        checks++;
        if (dbg_state !== S_WR_COMM) begin
          errors++;
          $display("FAIL %s capture_state: got %0d want %0d", name, dbg_state, S_WR_COMM);
        end
      end
    end
    @(negedge clk);
    w = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (ack) ack_cnt++;
    end
    checks++;
    if (ack_cnt !== 1) begin
      errors++;
      $display("FAIL %s ack_cycles: got %0d want 1", name, ack_cnt);
    end
    checks++;
    if (dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL %s end_state: got %0d want %0d", name, dbg_state, S_IDLE);
    end
  endtask

  task automatic do_read(input logic [15:0] a, input logic [7:0] exp, input string name);
    @(negedge clk);
    adress_bus = a;
    r = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dbg_state !== S_RD_WAIT || date_oe !== 1'b0) begin
      errors++;
      $display("FAIL %s capture: state=%0d oe=%b want state=%0d oe=0", name, dbg_state, date_oe, S_RD_WAIT);
    end
    @(negedge clk);
    adress_bus = a ^ 16'h0FFF;
    for (int k = 1; k <= RL + 1; k++) begin
      @(posedge clk); #1;
      if (k < RL + 1) begin
        checks++;
        if (date_oe !== 1'b0 || ack !== 1'b0) begin
          errors++;
          $display("FAIL %s early_drive k=%0d: oe=%b ack=%b want 0 0", name, k, date_oe, ack);
        end
      end else begin
        checks++;
        if (date_oe !== 1'b1 || ack !== 1'b1 || date_out !== exp) begin
          errors++;
          $display("FAIL %s data: oe=%b ack=%b data=%h want 1 1 %h", name, date_oe, ack, date_out, exp);
        end
      end
    end
    @(negedge clk);
    r = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (date_oe !== 1'b0 || ack !== 1'b0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL %s release: oe=%b ack=%b state=%0d want 0 0 0", name, date_oe, ack, dbg_state);
    end
  endtask

  task automatic do_miss_read(input logic [15:0] a, input string name);
    int seen;
    seen = 0;
    @(negedge clk);
    adress_bus = a;
    r = 1'b1;
    repeat (RL + 3) begin
      @(posedge clk); #1;
      if (date_oe || ack) seen++;
    end
    @(negedge clk);
    r = 1'b0;
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL %s miss_drive: active_cycles=%0d want 0", name, seen);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    adress_bus = 16'h0000;
    date_in = 8'h00;
    r = 1'b0;
    w = 1'b0;
    #12;
    checks++;
    if (date_oe !== 1'b0 || ack !== 1'b0 || access_err !== 1'b0 ||
        date_out !== 8'h00 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_values: oe=%b ack=%b err=%b out=%h st=%0d want 0 0 0 00 0",
               date_oe, ack, access_err, date_out, dbg_state);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    do_write(16'h2010, 8'hA5, 2, 1'b0, "basic_wr");
    do_read(16'h2010, 8'hA5, "basic_rd");
  endtask

  task automatic test_window_miss();
    do_miss_read(16'h1FFF, "miss_1fff");
    do_miss_read(16'h3000, "miss_3000");
    @(negedge clk);
    adress_bus = 16'h3010;
    date_in = 8'h77;
    w = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    w = 1'b0;
    @(posedge clk);
    do_read(16'h2010, 8'hA5, "miss_unchanged");
  endtask

  task automatic test_boundary();
    do_write(16'h2000, 8'h11, 2, 1'b0, "bnd_wr_lo");
    do_write(16'h2FFF, 8'hEE, 2, 1'b0, "bnd_wr_hi");
    do_read(16'h2000, 8'h11, "bnd_rd_lo");
    do_read(16'h2FFF, 8'hEE, "bnd_rd_hi");
  endtask

  task automatic test_contention();
    do_write(16'h2004, 8'h5A, 2, 1'b0, "cont_pre");
    @(negedge clk);
    adress_bus = 16'h2004;
    date_in = 8'hFF;
    r = 1'b1;
    w = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (access_err !== 1'b1 || date_oe !== 1'b0) begin
      errors++;
      $display("FAIL cont_err: err=%b oe=%b want 1 0", access_err, date_oe);
    end
    @(negedge clk);
    r = 1'b0;
    w = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (access_err !== 1'b1) begin
      errors++;
      $display("FAIL cont_sticky: err=%b want 1", access_err);
    end
    do_read(16'h2004, 8'h5A, "cont_mem");
  endtask

  task automatic test_long_write();
    do_write(16'h2020, 8'h3C, 5, 1'b1, "long_wr");
    do_read(16'h2020, 8'h3C, "long_rd");
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    adress_bus = 16'h2010;
    r = 1'b1;
    repeat (RL + 2) @(posedge clk);
    #1;
    checks++;
    if (date_oe !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_setup: oe=%b want 1", date_oe);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (date_oe !== 1'b0 || ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: oe=%b ack=%b want 0 0", date_oe, ack);
    end
    @(negedge clk);
    r = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dbg_state !== S_IDLE || ack !== 1'b0 || date_oe !== 1'b0 || access_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after: st=%0d ack=%b oe=%b err=%b want 0 0 0 0",
               dbg_state, ack, date_oe, access_err);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_window_miss();
    test_boundary();
    test_contention();
    test_long_write();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
